calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Sequencing controller for the four-digit add/subtract calculator.
- Consumes decoded keypad events and builds the two operands (0..9999, 14-bit binary) that drive the arithmetic core's op1/op2.
- Selects and latches the sum or difference result and its flags, then presents a registered display value to the downstream binary-to-BCD/display stage.
- Sits between the keypad decoder and the display driver; the arithmetic core itself stays purely combinational.

Parameters:
- NDIG, 4, maximum digits accepted per operand.
- W, 14, operand/result width in bits (must hold 10^NDIG-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is valid when high.
- key_code  input  4  0-9 digit, 10 '+', 11 '-', 12 '=', 13 clear, 14-15 unused.
- res_suma  input  W  sum from the arithmetic core (0 on overflow).
- res_resta  input  W  difference from the arithmetic core (0 when negative).
- f_OF  input  1  sum overflow flag (>9999).
- f_sig_res  input  1  negative-difference flag.
- op1  output  W  registered operand A to the arithmetic core.
- op2  output  W  registered operand B to the arithmetic core.
- disp_val  output  W  registered value to display.
- disp_err  output  1  overflow indication latched with the result.
- disp_neg  output  1  negative indication latched with the result.
- res_valid  output  1  one-cycle pulse when a result is latched.
- state_o  output  2  current state, for debug/LEDs: 0 S_OP1, 1 S_OP2, 2 S_RES.

Behaviour:
- Reset, asynchronous and applicable at any time, including mid-entry:
  - state S_OP1.
  - op1, op2, disp_val all 0.
  - disp_err, disp_neg, res_valid all 0.
  - digit counter 0; operator register = add.
- Key events act only in the cycle key_valid=1, one event per cycle. Codes 14-15 are ignored in every state.
- Clear (13): in any state, returns to the reset values in the next cycle.
- Digit accumulate: operand <= operand*10 + d, digit counter +1. Accepted only while counter < NDIG; further digits are ignored, and the operand and counter are unchanged. The product is computed at W+4 bits and truncated to W, and cannot exceed 9999 under the counter limit.
- S_OP1:
  - Digit: accumulates into op1; disp_val <= new op1.
  - '+' or '-': stores the operator, sets op2 = 0, digit counter = 0, goes to S_OP2. disp_val is unchanged.
  - '=': ignored.
- S_OP2:
  - Digit: accumulates into op2; disp_val <= new op2.
  - Operator with zero op2 digits entered: replaces the stored operator.
  - Operator after at least one digit: ignored (no implicit evaluation).
  - '=': latches the result in the same edge and goes to S_RES with res_valid=1 for exactly one cycle.
    - Add: disp_val <= res_suma, disp_err <= f_OF, disp_neg <= 0.
    - Sub: disp_val <= res_resta, disp_neg <= f_sig_res, disp_err <= 0.
    - The core is combinational, so the result reflects the op1/op2 registers in that cycle. Latency from the '=' strobe to disp_val is 1 clock.
    - '=' with zero op2 digits evaluates with op2 = 0.
- S_RES:
  - Digit: starts a new calculation. op1 <= d, counter = 1, op2 = 0, disp_err = disp_neg = 0, disp_val <= d, goes to S_OP1.
  - Operator (chaining): if disp_err=0, op1 <= disp_val, stores the operator, op2 = 0, counter = 0, disp_neg <= 0, goes to S_OP2. A negative result chains as 0. If disp_err=1 the operator is ignored.
  - '=': ignored; res_valid is not re-pulsed.
- op1/op2 change only on the events above and otherwise hold. res_valid is 0 on every other cycle.

Test Plan:
- Keys 1,2,3,4,'+',5,'=' -> op1=1234, op2=5, disp_val=1239, disp_err=0, res_valid one pulse, state S_RES.
- Keys 9,9,9,9,'+',1,'=' -> disp_val=0, disp_err=1. A following '+' is ignored (state stays S_RES); a following digit 7 gives op1=7, disp_err=0.
- Keys 3,'-',8,'=' -> disp_val=0, disp_neg=1. Then '+',2,'=' -> op1=0, disp_val=2, disp_neg=0.
- Keys 1,2,3,4,5 -> op1=1234 (fifth digit ignored). Then '+','-',1,'=' -> subtraction used, disp_val=1233.
- Keys 5,'+',5,'=' then '+',1,0,'=' -> first disp_val=10, chained disp_val=20, two res_valid pulses.
- Keys 4,'+',6, then rst asserted asynchronously mid-cycle -> all outputs 0 immediately, state S_OP1; clear key (13) in S_OP2 gives the same result on the next edge.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_seq_ctrl : keypad sequencing, operand build and result latch for the  |
// |                 four-digit add/subtract calculator.  Rev 1.0               |
// +----------------------------------------------------------------------------+
module calc_seq_ctrl #(
  parameter int NDIG = 4,
  parameter int W    = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic [W-1:0] res_suma,
  input  logic [W-1:0] res_resta,
  input  logic         f_OF,
  input  logic         f_sig_res,
  output logic [W-1:0] op1,
  output logic [W-1:0] op2,
  output logic [W-1:0] disp_val,
  output logic         disp_err,
  output logic         disp_neg,
  output logic         res_valid,
  output logic [1:0]   state_o
);

  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_OP1 = 2'd0,
    S_OP2 = 2'd1,
    S_RES = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   op1_q, op1_d;
  logic [W-1:0]   op2_q, op2_d;
  logic [W-1:0]   disp_val_q, disp_val_d;
  logic           disp_err_q, disp_err_d;
  logic           disp_neg_q, disp_neg_d;
  logic           res_valid_q, res_valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           op_sub_q, op_sub_d;

  logic           is_digit, is_op, is_eq, is_clr, can_acc;
  logic [W-1:0]   acc_src, acc;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_op    = key_valid && ((key_code == 4'd10) || (key_code == 4'd11));
  assign is_eq    = key_valid && (key_code == 4'd12);
  assign is_clr   = key_valid && (key_code == 4'd13);
  assign can_acc  = (cnt_q < CW'(NDIG));

  // Digit counter bounds the value to 10^NDIG-1, so truncation to W never loses bits.
  assign acc_src = (state_q == S_OP1) ? op1_q : op2_q;
  assign acc     = W'((W+4)'(acc_src) * (W+4)'(10) + (W+4)'(key_code));

  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    disp_val_d  = disp_val_q;
    disp_err_d  = disp_err_q;
    disp_neg_d  = disp_neg_q;
    res_valid_d = 1'b0;
    cnt_d       = cnt_q;
    op_sub_d    = op_sub_q;

    if (is_clr) begin
      state_d    = S_OP1;
      op1_d      = '0;
      op2_d      = '0;
      disp_val_d = '0;
      disp_err_d = 1'b0;
      disp_neg_d = 1'b0;
      cnt_d      = '0;
      op_sub_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_OP1: begin
          if (is_digit && can_acc) begin
            op1_d      = acc;
            disp_val_d = acc;
            cnt_d      = cnt_q + CW'(1);
          end else if (is_op) begin
            op_sub_d = (key_code == 4'd11);
            op2_d    = '0;
            cnt_d    = '0;
            state_d  = S_OP2;
          end
        end
        S_OP2: begin
          if (is_digit && can_acc) begin
            op2_d      = acc;
            disp_val_d = acc;
            cnt_d      = cnt_q + CW'(1);
          end else if (is_op && (cnt_q == '0)) begin
            op_sub_d = (key_code == 4'd11);
          end else if (is_eq) begin
            if (op_sub_q) begin
              disp_val_d = res_resta;
              disp_neg_d = f_sig_res;
              disp_err_d = 1'b0;
            end else begin
              disp_val_d = res_suma;
              disp_err_d = f_OF;
              disp_neg_d = 1'b0;
            end
            res_valid_d = 1'b1;
            state_d     = S_RES;
          end
        end
        S_RES: begin
          if (is_digit) begin
            op1_d      = W'(key_code);
            op2_d      = '0;
            cnt_d      = CW'(1);
            disp_err_d = 1'b0;
            disp_neg_d = 1'b0;
            disp_val_d = W'(key_code);
            state_d    = S_OP1;
          end else if (is_op && !disp_err_q) begin
            // A negative difference was latched as 0, so it chains as 0.
            op1_d      = disp_val_q;
            op_sub_d   = (key_code == 4'd11);
            op2_d      = '0;
            cnt_d      = '0;
            disp_neg_d = 1'b0;
            state_d    = S_OP2;
          end
        end
        default: state_d = S_OP1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OP1;
      op1_q       <= '0;
      op2_q       <= '0;
      disp_val_q  <= '0;
      disp_err_q  <= 1'b0;
      disp_neg_q  <= 1'b0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
      op_sub_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      disp_val_q  <= disp_val_d;
      disp_err_q  <= disp_err_d;
      disp_neg_q  <= disp_neg_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
      op_sub_q    <= op_sub_d;
    end
  end

  assign op1       = op1_q;
  assign op2       = op2_q;
  assign disp_val  = disp_val_q;
  assign disp_err  = disp_err_q;
  assign disp_neg  = disp_neg_q;
  assign res_valid = res_valid_q;
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_calc_seq_ctrl : vector table, reset sequences and random keys vs model. |
// |                    Rev 1.0                                                 |
// +----------------------------------------------------------------------------+
module tb_calc_seq_ctrl;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'd0;
  logic [W-1:0] res_suma, res_resta;
  logic         f_OF, f_sig_res;
  logic [W-1:0] op1, op2, disp_val;
  logic         disp_err, disp_neg, res_valid;
  logic [1:0]   state_o;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.NDIG(4), .W(W)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .res_suma(res_suma), .res_resta(res_resta), .f_OF(f_OF), .f_sig_res(f_sig_res),
    .op1(op1), .op2(op2), .disp_val(disp_val), .disp_err(disp_err),
    .disp_neg(disp_neg), .res_valid(res_valid), .state_o(state_o)
  );

  // Combinational arithmetic core the controller drives.
  always_comb begin
    int s, d;
    s = int'(op1) + int'(op2);
    d = int'(op1) - int'(op2);
    f_OF      = (s > 9999);
    res_suma  = f_OF ? '0 : W'(s);
    f_sig_res = (d < 0);
    res_resta = f_sig_res ? '0 : W'(d);
  end

  // Calculator reference model in plain integers.
  int m_mode, m_a, m_b, m_nd, m_dv;
  bit m_sub, m_err, m_neg, m_rv;

  function automatic void model_reset();
    m_mode = 0; m_a = 0; m_b = 0; m_nd = 0; m_dv = 0;
    m_sub = 0; m_err = 0; m_neg = 0; m_rv = 0;
  endfunction

  function automatic void model_key(int k);
    m_rv = 0;
    if (k == 13) begin model_reset(); return; end
    if (k >= 14) return;
    case (m_mode)
      0: begin
        if (k <= 9) begin
          if (m_nd < 4) begin m_a = m_a * 10 + k; m_nd++; m_dv = m_a; end
        end else if (k == 10 || k == 11) begin
          m_sub = (k == 11); m_b = 0; m_nd = 0; m_mode = 1;
        end
      end
      1: begin
        if (k <= 9) begin
          if (m_nd < 4) begin m_b = m_b * 10 + k; m_nd++; m_dv = m_b; end
        end else if (k == 10 || k == 11) begin
          if (m_nd == 0) m_sub = (k == 11);
        end else if (k == 12) begin
          if (!m_sub) begin
            m_err = (m_a + m_b > 9999); m_dv = m_err ? 0 : m_a + m_b; m_neg = 0;
          end else begin
            m_neg = (m_a < m_b); m_dv = m_neg ? 0 : m_a - m_b; m_err = 0;
          end
          m_rv = 1; m_mode = 2;
        end
      end
      default: begin
        if (k <= 9) begin
          m_a = k; m_nd = 1; m_b = 0; m_err = 0; m_neg = 0; m_dv = k; m_mode = 0;
        end else if ((k == 10 || k == 11) && !m_err) begin
          m_a = m_dv; m_sub = (k == 11); m_b = 0; m_nd = 0; m_neg = 0; m_mode = 1;
        end
      end
    endcase
  endfunction

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step(input bit kv, input int kc);
    @(negedge clk);
    key_valid = kv;
    key_code  = 4'(kc);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    if (kv) model_key(kc); else m_rv = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " op1"}, int'(op1), m_a);
    chk({tag, " op2"}, int'(op2), m_b);
    chk({tag, " disp_val"}, int'(disp_val), m_dv);
    chk({tag, " disp_err"}, int'(disp_err), int'(m_err));
    chk({tag, " disp_neg"}, int'(disp_neg), int'(m_neg));
    chk({tag, " res_valid"}, int'(res_valid), int'(m_rv));
    chk({tag, " state"}, int'(state_o), m_mode);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " op1"}, int'(op1), 0);
    chk({tag, " op2"}, int'(op2), 0);
    chk({tag, " disp_val"}, int'(disp_val), 0);
    chk({tag, " disp_err"}, int'(disp_err), 0);
    chk({tag, " disp_neg"}, int'(disp_neg), 0);
    chk({tag, " res_valid"}, int'(res_valid), 0);
    chk({tag, " state"}, int'(state_o), 0);
  endtask

  typedef struct {
    bit kv; int kc;
    int op1, op2, dv; bit err, neg, rv; int st;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit kv, input int kc, input int o1, input int o2, input int dv,
                     input bit err, input bit neg, input bit rv, input int st);
    vec_t v;
    v.kv = kv; v.kc = kc; v.op1 = o1; v.op2 = o2; v.dv = dv;
    v.err = err; v.neg = neg; v.rv = rv; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    // 1,2,3,4,+,5,= then a repeated '='
    add(1,13, 0,0,0, 0,0,0, 0);
    add(1,1, 1,0,1, 0,0,0, 0);
    add(1,2, 12,0,12, 0,0,0, 0);
    add(1,3, 123,0,123, 0,0,0, 0);
    add(1,4, 1234,0,1234, 0,0,0, 0);
    add(1,10, 1234,0,1234, 0,0,0, 1);
    add(1,5, 1234,5,5, 0,0,0, 1);
    add(1,12, 1234,5,1239, 0,0,1, 2);
    add(1,12, 1234,5,1239, 0,0,0, 2);
    // overflow, ignored operator, fresh digit
    add(1,13, 0,0,0, 0,0,0, 0);
    add(1,9, 9,0,9, 0,0,0, 0);
    add(1,9, 99,0,99, 0,0,0, 0);
    add(1,9, 999,0,999, 0,0,0, 0);
    add(1,9, 9999,0,9999, 0,0,0, 0);
    add(1,10, 9999,0,9999, 0,0,0, 1);
    add(1,1, 9999,1,1, 0,0,0, 1);
    add(1,12, 9999,1,0, 1,0,1, 2);
    add(1,10, 9999,1,0, 1,0,0, 2);
    add(1,7, 7,0,7, 0,0,0, 0);
    // negative difference chains as 0; '=' in S_OP1 ignored
    add(1,13, 0,0,0, 0,0,0, 0);
    add(1,3, 3,0,3, 0,0,0, 0);
    add(1,12, 3,0,3, 0,0,0, 0);
    add(1,11, 3,0,3, 0,0,0, 1);
    add(1,8, 3,8,8, 0,0,0, 1);
    add(1,12, 3,8,0, 0,1,1, 2);
    add(1,10, 0,0,0, 0,0,0, 1);
    add(1,2, 0,2,2, 0,0,0, 1);
    add(1,12, 0,2,2, 0,0,1, 2);
    // fifth digit, unused code, idle cycle, operator replacement
    add(1,13, 0,0,0, 0,0,0, 0);
    add(1,1, 1,0,1, 0,0,0, 0);
    add(1,2, 12,0,12, 0,0,0, 0);
    add(1,3, 123,0,123, 0,0,0, 0);
    add(1,4, 1234,0,1234, 0,0,0, 0);
    add(1,5, 1234,0,1234, 0,0,0, 0);
    add(1,14, 1234,0,1234, 0,0,0, 0);
    add(0,5, 1234,0,1234, 0,0,0, 0);
    add(1,10, 1234,0,1234, 0,0,0, 1);
    add(1,11, 1234,0,1234, 0,0,0, 1);
    add(1,1, 1234,1,1, 0,0,0, 1);
    add(1,12, 1234,1,1233, 0,0,1, 2);
    // chaining, operator after a digit ignored
    add(1,13, 0,0,0, 0,0,0, 0);
    add(1,5, 5,0,5, 0,0,0, 0);
    add(1,10, 5,0,5, 0,0,0, 1);
    add(1,5, 5,5,5, 0,0,0, 1);
    add(1,11, 5,5,5, 0,0,0, 1);
    add(1,12, 5,5,10, 0,0,1, 2);
    add(1,10, 10,0,10, 0,0,0, 1);
    add(1,1, 10,1,1, 0,0,0, 1);
    add(1,0, 10,10,10, 0,0,0, 1);
    add(1,12, 10,10,20, 0,0,1, 2);
    add(0,3, 10,10,20, 0,0,0, 2);
    // '=' with no op2 digits
    add(1,13, 0,0,0, 0,0,0, 0);
    add(1,7, 7,0,7, 0,0,0, 0);
    add(1,11, 7,0,7, 0,0,0, 1);
    add(1,12, 7,0,7, 0,0,1, 2);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].kv, tbl[i].kc);
      chk({tag, " op1"}, int'(op1), tbl[i].op1);
      chk({tag, " op2"}, int'(op2), tbl[i].op2);
      chk({tag, " disp_val"}, int'(disp_val), tbl[i].dv);
      chk({tag, " disp_err"}, int'(disp_err), int'(tbl[i].err));
      chk({tag, " disp_neg"}, int'(disp_neg), int'(tbl[i].neg));
      chk({tag, " res_valid"}, int'(res_valid), int'(tbl[i].rv));
      chk({tag, " state"}, int'(state_o), tbl[i].st);
    end

    // Asynchronous reset in the middle of operand entry
    step(1, 13); step(1, 4); step(1, 10); step(1, 6);
    chk("pre-rst op2", int'(op2), 6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Clear key in S_OP2
    step(1, 4); step(1, 10); step(1, 6);
    chk("pre-clr state", int'(state_o), 1);
    step(1, 13);
    chk_zero("clear");

    // Random keys against the model
    for (int n = 0; n < 800; n++) begin
      int r, kc;
      bit kv;
      r  = $urandom_range(0, 99);
      if (r < 55)      kc = $urandom_range(0, 9);
      else if (r < 68) kc = 10;
      else if (r < 80) kc = 11;
      else if (r < 94) kc = 12;
      else if (r < 97) kc = 13;
      else             kc = $urandom_range(14, 15);
      kv = ($urandom_range(0, 3) != 0);
      step(kv, kc);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
